// File: rtl/rw_bus_interface.sv
// 8254 read/write logic and data-bus buffer: decodes CPU bus cycles into per-counter
// control-word and initial-count updates, and serves latched count/status back to the CPU.
module rw_bus_interface #(
    parameter int NUM_CNT = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cs_n,
    input  logic                   rd_n,
    input  logic                   wr_n,
    input  logic [1:0]             addr,
    input  logic [7:0]             data_in,
    output logic [7:0]             data_out,
    output logic                   data_oe,
    output logic [8*NUM_CNT-1:0]   control_word,
    output logic [NUM_CNT-1:0]     cw_write,
    output logic [16*NUM_CNT-1:0]  initial_count,
    output logic [NUM_CNT-1:0]     load_new_count,
    input  logic [16*NUM_CNT-1:0]  current_count,
    input  logic [8*NUM_CNT-1:0]   status_byte
);

    logic [NUM_CNT-1:0][7:0]  cw_q, cw_d, sl_q, sl_d, sts;
    logic [NUM_CNT-1:0][15:0] ic_q, ic_d, cl_q, cl_d, cur;
    logic [NUM_CNT-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [NUM_CNT-1:0]       cfull_q, cfull_d, sfull_q, sfull_d;
    logic [NUM_CNT-1:0]       cww_q, cww_d, ld_q, ld_d;
    logic                     wr_q, rd_q, wblk_q, rblk_q;
    logic                     wr_ev, rd_done;
    logic [1:0]               sc;

    assign cur            = current_count;
    assign sts            = status_byte;
    assign control_word   = cw_q;
    assign initial_count  = ic_q;
    assign cw_write       = cww_q;
    assign load_new_count = ld_q;
    assign sc             = data_in[7:6];

    // A strobe held low across reset stays blocked until it has been seen high again.
    // A read ending together with a write strobe was a collision, not a read.
    assign wr_ev   = wr_q & ~wr_n & ~cs_n & rd_n & ~wblk_q;
    assign rd_done = ~rd_q & rd_n & ~cs_n & wr_q & ~rblk_q;

    function automatic logic [7:0] pick(input logic [1:0] rw, input logic ptr, input logic [15:0] v);
        pick = (rw == 2'b10 || (rw == 2'b11 && ptr)) ? v[15:8] : v[7:0];
    endfunction

    always_comb begin
        data_out = 8'h00;
        data_oe  = 1'b0;
        if (!cs_n && !rd_n && wr_n && addr != 2'd3) begin
            data_oe = 1'b1;
            if (sfull_q[addr])
                data_out = sl_q[addr];
            else if (cfull_q[addr])
                data_out = pick(cw_q[addr][5:4], rptr_q[addr], cl_q[addr]);
            else
                data_out = pick(cw_q[addr][5:4], rptr_q[addr], cur[addr]);
        end
    end

    always_comb begin
        cw_d    = cw_q;
        ic_d    = ic_q;
        cl_d    = cl_q;
        sl_d    = sl_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cfull_d = cfull_q;
        sfull_d = sfull_q;
        cww_d   = '0;
        ld_d    = '0;

        if (rd_done && addr != 2'd3) begin
            if (sfull_q[addr]) begin
                sfull_d[addr] = 1'b0;
            end else if (cw_q[addr][5:4] == 2'b11) begin
                rptr_d[addr] = ~rptr_q[addr];
                if (rptr_q[addr])
                    cfull_d[addr] = 1'b0;
            end else begin
                cfull_d[addr] = 1'b0;
            end
        end

        if (wr_ev) begin
            if (addr == 2'd3) begin
                if (sc == 2'b11) begin
                    for (int i = 0; i < NUM_CNT; i++) begin
                        if (data_in[i+1]) begin
                            if (!data_in[5] && !cfull_q[i]) begin
                                cfull_d[i] = 1'b1;
                                cl_d[i]    = cur[i];
                            end
                            if (!data_in[4] && !sfull_q[i]) begin
                                sfull_d[i] = 1'b1;
                                sl_d[i]    = sts[i];
                            end
                        end
                    end
                end else if (data_in[5:4] == 2'b00) begin
                    if (!cfull_q[sc]) begin
                        cfull_d[sc] = 1'b1;
                        cl_d[sc]    = cur[sc];
                    end
                end else begin
                    cw_d[sc]    = data_in;
                    cww_d[sc]   = 1'b1;
                    wptr_d[sc]  = 1'b0;
                    rptr_d[sc]  = 1'b0;
                    cfull_d[sc] = 1'b0;
                    sfull_d[sc] = 1'b0;
                end
            end else begin
                case (cw_q[addr][5:4])
                    2'b01: begin
                        ic_d[addr] = {8'h00, data_in};
                        ld_d[addr] = 1'b1;
                    end
                    2'b10: begin
                        ic_d[addr] = {data_in, 8'h00};
                        ld_d[addr] = 1'b1;
                    end
                    2'b11: begin
                        if (!wptr_q[addr]) begin
                            ic_d[addr][7:0] = data_in;
                            wptr_d[addr]    = 1'b1;
                        end else begin
                            ic_d[addr][15:8] = data_in;
                            ld_d[addr]       = 1'b1;
                            wptr_d[addr]     = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cw_q    <= '0;
            ic_q    <= '0;
            cl_q    <= '0;
            sl_q    <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cfull_q <= '0;
            sfull_q <= '0;
            cww_q   <= '0;
            ld_q    <= '0;
            wr_q    <= 1'b1;
            rd_q    <= 1'b1;
            wblk_q  <= 1'b1;
            rblk_q  <= 1'b1;
        end else begin
            cw_q    <= cw_d;
            ic_q    <= ic_d;
            cl_q    <= cl_d;
            sl_q    <= sl_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cfull_q <= cfull_d;
            sfull_q <= sfull_d;
            cww_q   <= cww_d;
            ld_q    <= ld_d;
            wr_q    <= wr_n;
            rd_q    <= rd_n;
            wblk_q  <= wblk_q & ~wr_n;
            rblk_q  <= rblk_q & ~rd_n;
        end
    end

endmodule

// File: doc/rw_bus_interface.md
Name: rw_bus_interface

Overview:
- Upstream bus front-end for the 8254 timer: the read/write logic and data-bus buffer.
- Decodes CPU bus cycles (cs_n, rd_n, wr_n, addr) into per-counter control-word writes and initial-count loads for the three control-logic/counting-element pairs.
- Sequences LSB/MSB byte access per RW mode.
- Implements counter-latch and read-back commands, and multiplexes latched count/status bytes back onto the data bus.

Parameters:
- NUM_CNT, 3, number of counters served (fixed at 3; addr 3 is the control register).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- cs_n  input  1  chip select, active low
- rd_n  input  1  read strobe, active low
- wr_n  input  1  write strobe, active low
- addr  input  2  A1:A0; 0..2 counter, 3 control word
- data_in  input  8  CPU write data
- data_out  output  8  CPU read data
- data_oe  output  1  bus driver enable
- control_word  output  24  per-counter mode byte, counter n at [8n+7:8n]
- cw_write  output  3  one-cycle pulse per counter on control-word write
- initial_count  output  48  per-counter 16-bit initial count, [16n+15:16n]
- load_new_count  output  3  one-cycle pulse when a counter's initial count is complete
- current_count  input  48  live count from each counting element
- status_byte  input  24  per-counter status from control logic

Behaviour:
- Reset:
  - All registers clear on the clk edge with reset=1. control_word=0, initial_count=0, all pulses=0, data_out=0, data_oe=0.
  - Write/read byte pointers reset to LSB. Count/status latches are empty.
- Event detection:
  - wr_n and rd_n are registered each cycle (wr_q, rd_q; reset value 1).
  - Write event: wr_q=1, wr_n=0, cs_n=0, rd_n=1.
  - Read-done event: rd_q=0, rd_n=1, cs_n=0.
  - rd_n=wr_n=0 simultaneously produces no event.
- Latency: register updates occur on the event edge. cw_write/load_new_count are registered and high for exactly the next cycle.
- Control write (addr=3), with SC=data_in[7:6]:
  - RW≠00: store byte in control_word[SC], pulse cw_write[SC], reset that counter's write and read pointers to LSB, clear its count/status latches.
  - RW=00 (counter latch): if the count latch of SC is empty, copy current_count[SC] into it. Ignored if already latched.
  - SC=11 (read-back):
    - COUNT_n=D5: latch count when 0.
    - STATUS_n=D4: latch status when 0.
    - Applies to counters selected by D1 (cnt0), D2 (cnt1), D3 (cnt2).
    - Already-full latches are unchanged.
    - control_word is not modified.
- Count write (addr=n<3), by RW of control_word[n]:
  - 01: low byte = data, high = 0, pulse load_new_count[n].
  - 10: high byte = data, low = 0, pulse load_new_count[n].
  - 11: a write at pointer LSB stores the low byte and moves the pointer to MSB. A write at pointer MSB stores the high byte, pulses load_new_count[n], and returns the pointer to LSB.
  - 00 (never programmed): write ignored.
- Read (addr=n<3, cs_n=0, rd_n=0):
  - data_oe=1; data_out is combinational from the current source.
  - Source priority: status latch if full; else count latch if full; else current_count[n].
  - Byte select follows RW with the read pointer, as for writes.
- On read-done:
  - If the status latch was the source, clear it.
  - Otherwise advance the byte pointer per RW. The count latch clears after its final byte: the MSB for mode 11, the single byte for 01/10.
- Reads of addr=3: data_oe=0, data_out=0, no state change.
- cs_n high: data_oe=0, data_out=0; no events.
- Reset asserted mid-access: all state returns to reset values. A pending strobe low at release generates no event until a fresh falling edge.

Test Plan:
- Reset, then write 0x34 to addr 3 → control_word[7:0]=0x34, cw_write=001 one cycle later for one cycle, counter-0 pointer LSB.
- After 0x34: write 0x10 then 0x27 to addr 0 → no load after first byte. After second: initial_count[15:0]=0x2710, load_new_count=001 for one cycle.
- Write 0x50 (cnt1, LSB only), then 0x05 to addr 1 → initial_count[31:16]=0x0005 and load pulse immediately. Write 0x60 (MSB only), then 0x12 → 0x1200.
- cnt0 mode 0x34 with current_count[15:0]=0xABCD. Write 0x04 (latch), change current_count to 0x1111, read addr 0 twice → 0xCD, 0xAB. A third read returns the live LSB 0x11.
- Read-back 0xC2 with status_byte[7:0]=0xB4, count 0x0102 → reads of addr 0 return 0xB4, 0x02, 0x01 in order, then latches empty.
- rd_n and wr_n low together, or cs_n high, while writing 0x55 to addr 0 → no state change, no pulses, data_oe=0. Reset mid-MSB-sequence → pointer back to LSB.
